// File: rtl/rgb_fpga_pkg.sv
// -----------------------------------------------------------------------------
// rgb_fpga_pkg
// Shared definitions for the RGB LED matrix row scheduler.
//   COLS / PIX_W / COL_AW : line geometry (32 columns of 8-bit pixels)
//   pixel_t               : one pixel
//   line_t                : one full line, element [col]
//   sched_state_e         : row scheduler state encoding
//   is_last_col()         : true on the final column of a line
// -----------------------------------------------------------------------------
package rgb_fpga_pkg;

  localparam int COLS   = 32;
  localparam int PIX_W  = 8;
  localparam int COL_AW = 5;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [COLS-1:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_BLANK   = 3'd2,
    S_START   = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5,
    S_NEXT    = 3'd6
  } sched_state_e;

  function automatic logic is_last_col(input logic [COL_AW-1:0] col);
    return (col == COL_AW'(COLS - 1));
  endfunction

endpackage

// File: rtl/rgb_fpga_row_scheduler.sv
// -----------------------------------------------------------------------------
// rgb_fpga_row_scheduler
// Walks every row of one LED panel half: fetches the row's 32 pixels from the
// frame buffer, blanks the panel while the row address moves, kicks the PWM
// line engine and waits for it to finish (with a watchdog).
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   enable            : low forces the sequencer back to IDLE
//   continuous        : 1 = free-running frames, 0 = one frame per frame_start
//   frame_start       : start strobe, only honoured in IDLE
//   fb_rd_en/fb_addr  : frame buffer read port, address {row, col}
//   fb_rd_data        : read data, one cycle after fb_rd_en
//   line_data         : captured pixels for the line engine, element [col]
//   line_en           : line engine enable (LOAD..NEXT)
//   line_start        : one-cycle start strobe
//   line_rdy          : engine handshake (drops on accept, rises when done)
//   row_addr          : panel row address
//   row_blank         : panel output blanked
//   frame_done        : pulse after the last row of a frame
//   timeout_err       : pulse when the engine fails to respond in time
//   busy              : sequencer is not IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module rgb_fpga_row_scheduler
  import rgb_fpga_pkg::*;
#(
  parameter int ROWS         = 16,
  parameter int ROW_AW       = 4,
  parameter int BLANK_CYC    = 4,
  parameter int LINE_TIMEOUT = 32768
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     continuous,
  input  logic                     frame_start,
  output logic                     fb_rd_en,
  output logic [ROW_AW+COL_AW-1:0] fb_addr,
  input  logic [PIX_W-1:0]         fb_rd_data,
  output line_t                    line_data,
  output logic                     line_en,
  output logic                     line_start,
  input  logic                     line_rdy,
  output logic [ROW_AW-1:0]        row_addr,
  output logic                     row_blank,
  output logic                     frame_done,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int TO_W = $clog2(LINE_TIMEOUT) + 1;
  localparam int BL_W = $clog2(BLANK_CYC) + 1;

  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(LINE_TIMEOUT - 1);
  localparam logic [BL_W-1:0]   BL_LAST  = BL_W'(BLANK_CYC - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);

  sched_state_e        state_q,       state_d;
  logic [ROW_AW-1:0]   row_q,         row_d;
  logic [COL_AW-1:0]   col_q,         col_d;
  logic                cap_vld_q,     cap_vld_d;
  logic [COL_AW-1:0]   cap_col_q,     cap_col_d;
  line_t               line_data_q,   line_data_d;
  logic [ROW_AW-1:0]   row_addr_q,    row_addr_d;
  logic                fb_rd_en_q,    fb_rd_en_d;
  logic                line_en_q,     line_en_d;
  logic                line_start_q,  line_start_d;
  logic                row_blank_q,   row_blank_d;
  logic                frame_done_q,  frame_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q,        busy_d;
  logic [BL_W-1:0]     blank_cnt_q,   blank_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,      to_cnt_d;

  // Next-state, fetch pipeline and output-register computation.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cap_vld_d     = 1'b0;
    cap_col_d     = col_q;
    line_data_d   = line_data_q;
    row_addr_d    = row_addr_q;
    fb_rd_en_d    = 1'b0;
    line_en_d     = line_en_q;
    line_start_d  = 1'b0;
    row_blank_d   = row_blank_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    blank_cnt_d   = blank_cnt_q;
    to_cnt_d      = to_cnt_q;

    if (!enable) begin
      // Same as reset, except the captured line is kept.
      state_d     = S_IDLE;
      row_d       = {ROW_AW{1'b0}};
      col_d       = {COL_AW{1'b0}};
      row_addr_d  = {ROW_AW{1'b0}};
      line_en_d   = 1'b0;
      row_blank_d = 1'b1;
      blank_cnt_d = {BL_W{1'b0}};
      to_cnt_d    = {TO_W{1'b0}};
    end else begin
      // Read data trails fb_rd_en by one cycle, so it belongs to the column
      // issued on the previous cycle (cap_col_q).
      cap_vld_d = fb_rd_en_q;
      cap_col_d = col_q;
      if ((state_q == S_LOAD) && cap_vld_q) begin
        line_data_d[cap_col_q] = fb_rd_data;
      end else begin
        line_data_d = line_data_q;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_start || continuous) begin
            state_d    = S_LOAD;
            row_d      = {ROW_AW{1'b0}};
            col_d      = {COL_AW{1'b0}};
            fb_rd_en_d = 1'b1;
            line_en_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_LOAD: begin
          if (fb_rd_en_q && !is_last_col(col_q)) begin
            col_d      = col_q + COL_AW'(1'b1);
            fb_rd_en_d = 1'b1;
          end else begin
            col_d      = col_q;
            fb_rd_en_d = 1'b0;
          end
          // Leave once the final column's data has been written.
          if (cap_vld_q && is_last_col(cap_col_q)) begin
            state_d     = S_BLANK;
            row_addr_d  = row_q;
            row_blank_d = 1'b1;
            blank_cnt_d = {BL_W{1'b0}};
          end else begin
            state_d = S_LOAD;
          end
        end

        S_BLANK: begin
          if (blank_cnt_q == BL_LAST) begin
            state_d      = S_START;
            line_start_d = 1'b1;
            row_blank_d  = 1'b0;
            to_cnt_d     = {TO_W{1'b0}};
          end else begin
            blank_cnt_d = blank_cnt_q + BL_W'(1'b1);
          end
        end

        S_START: begin
          state_d  = S_WAIT_LO;
          to_cnt_d = {TO_W{1'b0}};
        end

        S_WAIT_LO, S_WAIT_HI: begin
          // The watchdog wins over a handshake arriving on the same cycle.
          if (to_cnt_q == TO_LAST) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            line_en_d     = 1'b0;
            row_blank_d   = 1'b1;
            row_d         = {ROW_AW{1'b0}};
            col_d         = {COL_AW{1'b0}};
            to_cnt_d      = {TO_W{1'b0}};
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1'b1);
            if ((state_q == S_WAIT_LO) && !line_rdy) begin
              state_d = S_WAIT_HI;
            end else if ((state_q == S_WAIT_HI) && line_rdy) begin
              state_d      = S_NEXT;
              row_blank_d  = 1'b1;
              frame_done_d = (row_q == ROW_LAST);
            end else begin
              state_d = state_q;
            end
          end
        end

        S_NEXT: begin
          col_d       = {COL_AW{1'b0}};
          row_blank_d = 1'b1;
          if (row_q != ROW_LAST) begin
            row_d      = row_q + ROW_AW'(1'b1);
            state_d    = S_LOAD;
            fb_rd_en_d = 1'b1;
          end else begin
            row_d = {ROW_AW{1'b0}};
            if (continuous) begin
              state_d    = S_LOAD;
              fb_rd_en_d = 1'b1;
            end else begin
              state_d   = S_IDLE;
              line_en_d = 1'b0;
            end
          end
        end

        default: begin
          state_d     = S_IDLE;
          row_d       = {ROW_AW{1'b0}};
          col_d       = {COL_AW{1'b0}};
          line_en_d   = 1'b0;
          row_blank_d = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= {ROW_AW{1'b0}};
      col_q         <= {COL_AW{1'b0}};
      cap_vld_q     <= 1'b0;
      cap_col_q     <= {COL_AW{1'b0}};
      line_data_q   <= '0;
      row_addr_q    <= {ROW_AW{1'b0}};
      fb_rd_en_q    <= 1'b0;
      line_en_q     <= 1'b0;
      line_start_q  <= 1'b0;
      row_blank_q   <= 1'b1;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      blank_cnt_q   <= {BL_W{1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cap_vld_q     <= cap_vld_d;
      cap_col_q     <= cap_col_d;
      line_data_q   <= line_data_d;
      row_addr_q    <= row_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      line_en_q     <= line_en_d;
      line_start_q  <= line_start_d;
      row_blank_q   <= row_blank_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      blank_cnt_q   <= blank_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign fb_rd_en    = fb_rd_en_q;
  assign fb_addr     = {row_q, col_q};
  assign line_data   = line_data_q;
  assign line_en     = line_en_q;
  assign line_start  = line_start_q;
  assign row_addr    = row_addr_q;
  assign row_blank   = row_blank_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rgb_fpga_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rgb_fpga_row_scheduler
// Self-checking bench: a frame buffer model with random or ramp contents, a
// line engine model with random handshake delays, and per-scenario tasks that
// compare the scheduler against frame-level expectations.
// -----------------------------------------------------------------------------
module tb_rgb_fpga_row_scheduler;
  import rgb_fpga_pkg::*;

  localparam int ROWS = 16;
  localparam int ROW_AW = 4;
  localparam int BLANK_CYC = 4;
  localparam int LINE_TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst, enable, continuous, frame_start;
  logic fb_rd_en;
  logic [ROW_AW+COL_AW-1:0] fb_addr;
  logic [7:0] fb_rd_data;
  line_t line_data;
  logic line_en, line_start, line_rdy;
  logic [ROW_AW-1:0] row_addr;
  logic row_blank, frame_done, timeout_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [ROWS*COLS];
  bit eng_stuck = 1'b0;

  rgb_fpga_row_scheduler #(
    .ROWS(ROWS), .ROW_AW(ROW_AW), .BLANK_CYC(BLANK_CYC), .LINE_TIMEOUT(LINE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .continuous(continuous),
    .frame_start(frame_start), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
    .fb_rd_data(fb_rd_data), .line_data(line_data), .line_en(line_en),
    .line_start(line_start), .line_rdy(line_rdy), .row_addr(row_addr),
    .row_blank(row_blank), .frame_done(frame_done), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame buffer: a read issued in one cycle returns data in the next; junk otherwise.
  initial begin
    bit pend;
    int pend_addr;
    pend = 1'b0;
    pend_addr = 0;
    fb_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (pend) fb_rd_data = mem[pend_addr];
      else fb_rd_data = 8'($urandom);
      pend = fb_rd_en;
      pend_addr = int'(fb_addr);
    end
  end

  // Line engine: after a start, drop ready after 0..3 cycles, raise it 1..8 cycles later.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    line_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (eng_stuck) begin
        line_rdy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: begin
            line_rdy = 1'b1;
            if (line_start) begin
              phase = 1;
              cnt = int'($urandom_range(0, 3));
            end
          end
          1: begin
            if (cnt == 0) begin
              line_rdy = 1'b0;
              phase = 2;
              cnt = int'($urandom_range(1, 8));
            end else cnt--;
          end
          default: begin
            if (cnt == 0) begin
              line_rdy = 1'b1;
              phase = 0;
            end else cnt--;
          end
        endcase
      end
    end
  end

  function automatic line_t model_line(input int r);
    line_t l;
    for (int c = 0; c < COLS; c++) l[c] = mem[r*COLS + c];
    return l;
  endfunction

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; continuous = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fb_rd_en, line_en, line_start, row_blank, frame_done, timeout_err, busy} !== 7'b0001000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0001000",
               {fb_rd_en, line_en, line_start, row_blank, frame_done, timeout_err, busy});
    end
    n_cmp++;
    if (row_addr !== 4'd0 || line_data !== '0 || fb_addr !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_data: row_addr %0d fb_addr %0d line_data %h, want zeros", row_addr, fb_addr, line_data);
    end
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame(input bit ramp);
    int starts, dones, fetch, blank_run;
    bit done, pend_idle;
    logic [ROW_AW-1:0] prev_ra;
    bit prev_blank;
    line_t row2;
    fill_mem(ramp);
    continuous = 1'b0;
    enable = 1'b1;
    starts = 0; dones = 0; fetch = 0; blank_run = 0;
    done = 1'b0; pend_idle = 1'b0; row2 = '0;
    prev_ra = row_addr; prev_blank = row_blank;
    pulse_start();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (fb_rd_en) begin
        n_cmp++;
        if (fb_addr !== 9'(fetch)) begin
          n_bad++;
          $display("FAIL fetch_order: fb_addr %0d want %0d", fb_addr, fetch);
        end
        fetch++;
      end
      if (row_addr !== prev_ra) begin
        n_cmp++;
        if (!(row_blank && prev_blank)) begin
          n_bad++;
          $display("FAIL row_addr_unblanked: row_addr %0d->%0d with blank %0b/%0b, want 1/1",
                   prev_ra, row_addr, prev_blank, row_blank);
        end
      end
      if (line_start) begin
        n_cmp++;
        if (row_addr !== 4'(starts)) begin
          n_bad++;
          $display("FAIL start_row: row_addr %0d want %0d", row_addr, starts);
        end
        n_cmp++;
        if (line_data !== model_line(starts)) begin
          n_bad++;
          $display("FAIL line_data row %0d: got %h want %h", starts, line_data, model_line(starts));
        end
        n_cmp++;
        if (blank_run < BLANK_CYC) begin
          n_bad++;
          $display("FAIL blank_before_start: %0d blank cycles, want >= %0d", blank_run, BLANK_CYC);
        end
        if (starts == 2) row2 = line_data;
        starts++;
      end
      blank_run = row_blank ? blank_run + 1 : 0;
      if (pend_idle) begin
        n_cmp++;
        if (busy !== 1'b0 || line_en !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_after_frame: busy %0b line_en %0b want 0 0", busy, line_en);
        end
        done = 1'b1;
      end
      if (frame_done) begin
        dones++;
        pend_idle = 1'b1;
      end
      prev_ra = row_addr;
      prev_blank = row_blank;
      @(negedge clk);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL frame_timeout: frame not finished, done %0b want 1", done);
    end
    n_cmp++;
    if (starts != ROWS || dones != 1 || fetch != ROWS*COLS) begin
      n_bad++;
      $display("FAIL frame_counts: starts %0d dones %0d reads %0d want %0d 1 %0d",
               starts, dones, fetch, ROWS, ROWS*COLS);
    end
    if (ramp) begin
      n_cmp++;
      if (row2[5] !== 8'd69) begin
        n_bad++;
        $display("FAIL ramp_row2_col5: got %0d want 69", row2[5]);
      end
    end
  endtask

  task automatic test_continuous();
    int starts;
    bit seen;
    fill_mem(1'b0);
    starts = 0;
    seen = 1'b0;
    continuous = 1'b1;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(negedge clk);
      if (line_start) starts++;
      if (frame_done) seen = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!seen || starts != ROWS) begin
      n_bad++;
      $display("FAIL cont_frame: frame_done seen %0b starts %0d want 1 %0d", seen, starts, ROWS);
    end
    n_cmp++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 9'd0 || busy !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_restart: rd_en %0b addr %0d busy %0b done %0b want 1 0 1 0",
               fb_rd_en, fb_addr, busy, frame_done);
    end
    enable = 1'b0;
    continuous = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_disable: busy %0b want 0", busy);
    end
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    bit hit;
    line_t exp7;
    fill_mem(1'b0);
    exp7 = model_line(7);
    hit = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
      if (line_start && row_addr == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    eng_stuck = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!hit || row_addr !== 4'd0 || line_en !== 1'b0 || row_blank !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_drop: hit %0b row_addr %0d line_en %0b blank %0b busy %0b want 1 0 0 1 0",
               hit, row_addr, line_en, row_blank, busy);
    end
    n_cmp++;
    if (line_data !== exp7) begin
      n_bad++;
      $display("FAIL enable_drop_hold: line_data %h want %h", line_data, exp7);
    end
    eng_stuck = 1'b0;
    enable = 1'b1;
    pulse_start();
    n_cmp++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 9'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_row0: rd_en %0b addr %0d busy %0b want 1 0 1", fb_rd_en, fb_addr, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit hit;
    int cnt;
    eng_stuck = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (line_start) hit = 1'b1;
      else @(negedge clk);
    end
    cnt = 0;
    while (hit && cnt < 300 && !timeout_err) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (!hit || cnt != LINE_TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: start seen %0b, timeout_err %0d cycles after line_start, want %0d",
               hit, cnt, LINE_TIMEOUT + 1);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || line_en !== 1'b0 || row_blank !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_outputs: err %0b line_en %0b blank %0b busy %0b want 1 0 1 0",
               timeout_err, line_en, row_blank, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: err %0b busy %0b want 0 0", timeout_err, busy);
    end
    eng_stuck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit hit;
    hit = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (fb_rd_en && fb_addr[4:0] == 5'd12) hit = 1'b1;
      else @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!hit || {fb_rd_en, line_en, line_start, row_blank, frame_done, timeout_err, busy} !== 7'b0001000) begin
      n_bad++;
      $display("FAIL reset_in_load_ctrl: hit %0b got %b want 0001000", hit,
               {fb_rd_en, line_en, line_start, row_blank, frame_done, timeout_err, busy});
    end
    n_cmp++;
    if (row_addr !== 4'd0 || line_data !== '0 || fb_addr !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_in_load_data: row_addr %0d fb_addr %0d line_data %h want zeros",
               row_addr, fb_addr, line_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; continuous = 1'b0; frame_start = 1'b0;
    test_reset();
    test_single_frame(1'b1);
    test_single_frame(1'b0);
    test_continuous();
    test_enable_drop();
    test_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
